// File: rtl/op_key_decoder.sv
// op_key_decoder: debounces one-hot operation keys and emits one opcode event per press.
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   btn_i    registered one-hot key levels (1000 add, 0100 sub, 0010 mul, 0001 div)
//   op_valid opcode event pending in the one-entry buffer
//   op_ready core accepts the pending event this cycle
//   op_code  00 add, 01 sub, 10 mul, 11 div
//   drop_o   sticky: an event was lost because the buffer was still occupied
module op_key_decoder #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_i,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [1:0] op_code,
  output logic       drop_o
);
  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0] cand, cand_n, q;
  logic emit, last;
  logic [1:0] enc;
  // Anything that is not exactly one key is treated as no key.
  assign q = (btn_i inside {4'b1000, 4'b0100, 4'b0010, 4'b0001}) ? btn_i : 4'b0000;
  assign last = cnt == CNT_W'(DEB_CYCLES - 1);
  assign enc = {cand[1] | cand[0], cand[2] | cand[0]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      cand <= 4'b0000;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cand <= cand_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cand_n = cand;
    emit = 1'b0;
    case (state)
      IDLE:
        if (q != 4'b0000) begin
          cand_n = q;
          cnt_n = '0;
          state_n = DEB_PRESS;
        end
      DEB_PRESS:
        if (q != cand) state_n = IDLE;
        else if (last) begin
          emit = 1'b1;
          state_n = HELD;
        end else cnt_n = cnt + 1'b1;
      HELD:
        if (q != cand) begin
          cnt_n = '0;
          state_n = DEB_REL;
        end
      DEB_REL:
        if (q == cand) state_n = HELD;
        else if (last) state_n = IDLE;
        else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // A new event may replace one that is being accepted on the same edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_valid <= 1'b0;
      op_code <= 2'b00;
      drop_o <= 1'b0;
    end else if (emit && (!op_valid || op_ready)) begin
      op_valid <= 1'b1;
      op_code <= enc;
    end else begin
      if (emit) drop_o <= 1'b1;
      if (op_ready) op_valid <= 1'b0;
    end
endmodule

// File: tb/tb_op_key_decoder.sv
// tb_op_key_decoder: directed and random checks of op_key_decoder against a run-length model.
module tb_op_key_decoder;
  localparam int DEB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic rdy = 1'b0;
  logic op_valid, drop_o;
  logic [1:0] op_code;
  int nvec = 0;
  int nerr = 0;
  int vc, bad;
  bit down;
  int run, rrun;
  logic [3:0] k;
  logic mv, md;
  logic [1:0] mc;

  op_key_decoder #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn_i(btn), .op_valid(op_valid),
    .op_ready(rdy), .op_code(op_code), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] qual(logic [3:0] b);
    return $onehot(b) ? b : 4'b0000;
  endfunction

  function automatic logic [1:0] code_of(logic [3:0] key);
    return key[3] ? 2'd0 : key[2] ? 2'd1 : key[1] ? 2'd2 : 2'd3;
  endfunction

  // Model: a press is accepted after DEB+1 consecutive samples of the same key
  // starting from the released state; a release after DEB+1 consecutive
  // samples that differ from the held key.
  initial forever begin
    logic [3:0] q;
    bit emit;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      down = 0; run = 0; rrun = 0; k = 4'b0000;
      mv = 0; mc = 2'd0; md = 0;
    end else begin
      q = qual(btn);
      emit = 0;
      if (!down) begin
        if (run > 0 && q == k) begin
          run++;
          if (run == DEB + 1) begin emit = 1; down = 1; rrun = 0; run = 0; end
        end else if (run > 0) run = 0;
        else if (q != 4'b0000) begin k = q; run = 1; end
      end else begin
        rrun = (q != k) ? rrun + 1 : 0;
        if (rrun == DEB + 1) begin down = 0; run = 0; end
      end
      if (emit && (!mv || rdy)) begin mv = 1; mc = code_of(k); end
      else begin
        if (emit) md = 1;
        if (rdy) mv = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      nvec++;
      if ({op_valid, op_code, drop_o} !== {mv, mc, md}) begin
        nerr++;
        $display("FAIL model t=%0t valid/code/drop got %b/%b/%b want %b/%b/%b",
                 $time, op_valid, op_code, drop_o, mv, mc, md);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] b, input logic r);
    btn = b;
    rdy = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    btn = 4'b0000;
    rdy = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("reset_valid", int'(op_valid), 0);
    chk("reset_code", int'(op_code), 0);
    chk("reset_drop", int'(drop_o), 0);
    // 1: single press held long
    repeat (DEB) step(4'b0100, 1);
    chk("t1_latency", int'(op_valid), 0);
    step(4'b0100, 1);
    chk("t1_valid", int'(op_valid), 1);
    chk("t1_code", int'(op_code), 1);
    vc = 0;
    repeat (100) begin step(4'b0100, 1); vc += int'(op_valid); end
    chk("t1_once", vc, 0);
    chk("t1_drop", int'(drop_o), 0);
    // 2: bounce then stable
    vc = 0;
    repeat (6) begin step(4'b0000, 1); vc += int'(op_valid); end
    repeat (2) begin step(4'b1000, 1); vc += int'(op_valid); end
    step(4'b0000, 1); vc += int'(op_valid);
    repeat (2) begin step(4'b1000, 1); vc += int'(op_valid); end
    repeat (6) begin step(4'b0000, 1); vc += int'(op_valid); end
    chk("t2_bounce", vc, 0);
    repeat (DEB) step(4'b1000, 1);
    step(4'b1000, 1);
    chk("t2_valid", int'(op_valid), 1);
    chk("t2_code", int'(op_code), 0);
    step(4'b1000, 1);
    chk("t2_consumed", int'(op_valid), 0);
    // 3: backpressure drop
    do_reset();
    repeat (DEB + 1) step(4'b0010, 0);
    chk("t3_valid", int'(op_valid), 1);
    bad = 0;
    repeat (6) begin step(4'b0000, 0); bad += int'(op_valid !== 1'b1 || op_code !== 2'd2); end
    repeat (DEB + 1) begin step(4'b0001, 0); bad += int'(op_valid !== 1'b1 || op_code !== 2'd2); end
    repeat (6) begin step(4'b0000, 0); bad += int'(op_valid !== 1'b1 || op_code !== 2'd2); end
    chk("t3_hold", bad, 0);
    chk("t3_drop", int'(drop_o), 1);
    step(4'b0000, 1);
    chk("t3_accept", int'(op_valid), 0);
    chk("t3_sticky", int'(drop_o), 1);
    // 4: accept and load on the same edge
    do_reset();
    repeat (DEB + 1) step(4'b0010, 0);
    repeat (6) step(4'b0000, 0);
    repeat (DEB) step(4'b0001, 0);
    step(4'b0001, 1);
    chk("t4_valid", int'(op_valid), 1);
    chk("t4_code", int'(op_code), 3);
    chk("t4_drop", int'(drop_o), 0);
    // 5: release glitch and direct key switch
    do_reset();
    repeat (DEB + 1) step(4'b0010, 1);
    chk("t5_first", int'(op_code), 2);
    vc = 0;
    repeat (2) begin step(4'b0000, 1); vc += int'(op_valid); end
    repeat (10) begin step(4'b0010, 1); vc += int'(op_valid); end
    chk("t5_glitch", vc, 0);
    vc = 0;
    repeat (2 * DEB + 1) begin step(4'b0001, 1); vc += int'(op_valid); end
    chk("t5_switch_wait", vc, 0);
    step(4'b0001, 1);
    chk("t5_switch_valid", int'(op_valid), 1);
    chk("t5_switch_code", int'(op_code), 3);
    // 6: asynchronous reset mid-debounce and mid-pending
    do_reset();
    repeat (2) step(4'b1000, 0);
    #2 rst_n = 1'b0;
    #1 chk("t6_rst1", int'({op_valid, op_code, drop_o}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DEB) step(4'b1000, 0);
    chk("t6_fresh1", int'(op_valid), 0);
    step(4'b1000, 0);
    chk("t6_event1", int'(op_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk("t6_rst2", int'({op_valid, op_code, drop_o}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DEB) step(4'b1000, 0);
    chk("t6_fresh2", int'(op_valid), 0);
    step(4'b1000, 0);
    chk("t6_event2", int'(op_valid), 1);
    chk("t6_code2", int'(op_code), 0);
    // random phase, checked every cycle by the model
    do_reset();
    begin
      logic [3:0] b;
      logic r;
      b = 4'b0000;
      r = 1'b1;
      repeat (4000) begin
        if ($urandom_range(0, 7) == 0) begin
          int p;
          p = $urandom_range(0, 9);
          b = (p < 3) ? 4'b0000 : (p < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
        end
        if ($urandom_range(0, 15) == 0) r = ~r;
        step(b, r);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
